// File: rtl/fetch_unit.sv
// fetch_unit: PC, program-memory read issue and 3-entry FWFT buffer.
// Optional FETCH_PREDECODE_EN adds instr_opcode/instr_is_flow outputs.
module fetch_unit (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] imem_addr,
  output logic       imem_rd,
  input  logic [9:0] imem_data,
  output logic [9:0] instr,
  output logic [7:0] instr_pc,
  output logic       instr_valid,
  input  logic       instr_ready,
  input  logic       redirect,
  input  logic [7:0] redirect_pc,
  input  logic       halt
`ifdef FETCH_PREDECODE_EN
  ,
  output logic [3:0] instr_opcode,
  output logic       instr_is_flow
`endif
);

  typedef enum logic [1:0] {RUN, HALT, FLUSH} state_t;

  state_t     state, stateNext;
  logic [7:0] pc;
  logic [9:0] bufWord [3];
  logic [7:0] bufPc   [3];
  logic [1:0] count, head, tail;
  logic       inFlight, discard;
  logic       push, pop;
  logic [2:0] pending;

  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  assign pending = {1'b0, count} + {2'b00, inFlight};
  assign push    = inFlight && !discard && !redirect;
  assign pop     = instr_valid && instr_ready;

  assign instr       = bufWord[head];
  assign instr_pc    = bufPc[head];
  assign instr_valid = (count != 2'd0);

`ifdef FETCH_PREDECODE_EN
  assign instr_opcode  = instr_valid ? instr[9:6] : 4'd0;
  assign instr_is_flow = instr_valid &&
                         (instr[9:6] inside {4'd4, 4'd9, 4'd10, 4'd14});
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= stateNext;
  end

  // next state: redirect wins over halt from any state
  always_comb begin
    stateNext = state;
    if (redirect) begin
      stateNext = FLUSH;
    end else begin
      unique case (state)
        RUN:     stateNext = halt ? HALT : RUN;
        HALT:    stateNext = halt ? HALT : RUN;
        FLUSH:   stateNext = halt ? HALT : RUN;
        default: stateNext = RUN;
      endcase
    end
  end

  // read issue: only when the buffer can absorb the returning word
  always_comb begin
    imem_addr = pc;
    imem_rd   = (state != HALT) && !halt && !redirect &&
                (pending < 3'd3);
  end

  // PC, in-flight tracking and buffer bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= 8'h00;
      inFlight <= 1'b0;
      discard  <= 1'b0;
      count    <= 2'd0;
      head     <= 2'd0;
      tail     <= 2'd0;
    end else begin
      inFlight <= imem_rd;
      discard  <= redirect && inFlight;
      if (redirect)     pc <= redirect_pc;
      else if (imem_rd) pc <= pc + 8'd1;
      if (redirect) begin
        count <= 2'd0;
        head  <= 2'd0;
        tail  <= 2'd0;
      end else begin
        if (push) tail <= inc3(tail);
        if (pop)  head <= inc3(head);
        unique case ({push, pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end
  end

  // buffer storage; the word returning now belongs to pc-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        bufWord[i] <= 10'd0;
        bufPc[i]   <= 8'd0;
      end
    end else if (push) begin
      bufWord[tail] <= imem_data;
      bufPc[tail]   <= pc - 8'd1;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard plus table-driven redirect runs
// and hand-written reset/backpressure/halt/flush sequences.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] imem_addr;
  logic       imem_rd;
  logic [9:0] imem_data = 10'd0;
  logic [9:0] instr;
  logic [7:0] instr_pc;
  logic       instr_valid;
  logic       instr_ready;
  logic       redirect;
  logic [7:0] redirect_pc;
  logic       halt;
`ifdef FETCH_PREDECODE_EN
  logic [3:0] instr_opcode;
  logic       instr_is_flow;
`endif

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_rd(imem_rd), .imem_data(imem_data),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .redirect(redirect),
    .redirect_pc(redirect_pc), .halt(halt)
`ifdef FETCH_PREDECODE_EN
    , .instr_opcode(instr_opcode), .instr_is_flow(instr_is_flow)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] memWord(input logic [7:0] a);
    if (a == 8'h80) return 10'h240;
    if (a == 8'h81) return 10'h140;
    return {2'b00, a};
  endfunction

  always @(posedge clk) imem_data <= memWord(imem_addr);

  typedef struct {
    logic [9:0] w;
    logic [7:0] pc;
  } item_t;

  typedef struct {
    logic [7:0] target;
    int         runCycles;
    int         expXfers;
    logic [7:0] expLast;
  } vec_t;

  item_t      q[$];
  item_t      it;
  logic [7:0] expPc;
  logic [7:0] lastPc;
  int         nCmp = 0;
  int         nBad = 0;
  int         nReads = 0;
  int         xfers = 0;
  vec_t       vecs[4];

  task automatic chk(input string name, input int act, input int exp);
    nCmp++;
    if (act != exp) begin
      nBad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sb();
    if (instr_valid && instr_ready) begin
      if (q.size() == 0) begin
        chk("sb_unexpected_xfer", 1, 0);
      end else begin
        it = q.pop_front();
        chk("sb_instr", int'(instr), int'(it.w));
        chk("sb_instr_pc", int'(instr_pc), int'(it.pc));
      end
      xfers++;
      lastPc = instr_pc;
    end
    if (imem_rd) begin
      chk("rd_addr", int'(imem_addr), int'(expPc));
      if (halt || redirect) chk("rd_blocked", 1, 0);
      it.w  = memWord(expPc);
      it.pc = expPc;
      q.push_back(it);
      expPc = expPc + 8'd1;
      nReads++;
      if (q.size() > 3) chk("rd_overfill", q.size(), 3);
    end
    if (redirect) begin
      q.delete();
      expPc = redirect_pc;
    end
  endtask

  task automatic cycle();
    sb();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) begin
      #1;
      cycle();
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    q.delete();
    expPc = 8'h00;
    #1;
    chk("rst_valid", int'(instr_valid), 0);
    chk("rst_instr", int'(instr), 0);
    chk("rst_instr_pc", int'(instr_pc), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic doRedirect(input logic [7:0] t);
    redirect    = 1'b1;
    redirect_pc = t;
    #1;
    chk("redir_rd", int'(imem_rd), 0);
    cycle();
    redirect = 1'b0;
    #1;
    chk("post_redir_valid", int'(instr_valid), 0);
    cycle();
  endtask

  initial begin
    logic found;
    vecs[0] = '{8'hFE, 5, 3, 8'h00};
    vecs[1] = '{8'h40, 3, 1, 8'h40};
    vecs[2] = '{8'h10, 10, 8, 8'h17};
    vecs[3] = '{8'hFF, 4, 2, 8'h00};

    rst_n = 1'b0; instr_ready = 1'b1; redirect = 1'b0;
    redirect_pc = 8'h00; halt = 1'b0;
    @(negedge clk);

    // reset release, streaming
    doReset();
    #1;
    chk("c0_rd", int'(imem_rd), 1);
    chk("c0_addr", int'(imem_addr), 0);
    chk("c0_valid", int'(instr_valid), 0);
    cycle();
    #1;
    chk("c1_valid", int'(instr_valid), 0);
    cycle();
    #1;
    chk("c2_valid", int'(instr_valid), 1);
    chk("c2_instr", int'(instr), 0);
    chk("c2_pc", int'(instr_pc), 0);
    cycle();
    for (int k = 1; k < 7; k++) begin
      #1;
      chk("stream_valid", int'(instr_valid), 1);
      chk("stream_pc", int'(instr_pc), k);
      cycle();
    end

    // mid-operation reset, then backpressure
    instr_ready = 1'b0;
    doReset();
    nReads = 0;
    run(6);
    #1;
    chk("bp_reads", nReads, 3);
    chk("bp_rd", int'(imem_rd), 0);
    chk("bp_valid", int'(instr_valid), 1);
    instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("bp_drain_pc", int'(instr_pc), k);
      cycle();
    end

    // redirect while 0x05 is in flight
    doReset();
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (imem_rd && imem_addr == 8'h05) begin
        found = 1'b1;
        cycle();
        break;
      end
      cycle();
    end
    chk("found_rd5", int'(found), 1);
    doRedirect(8'h40);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (instr_valid) begin
        found = 1'b1;
        chk("redir_first_pc", int'(instr_pc), 8'h40);
        cycle();
        break;
      end
      cycle();
    end
    chk("redir_valid_seen", int'(found), 1);

    // table-driven redirect runs, incl. PC wrap
    for (int v = 0; v < 4; v++) begin
      redirect    = 1'b1;
      redirect_pc = vecs[v].target;
      #1;
      cycle();
      redirect = 1'b0;
      xfers    = 0;
      lastPc   = 8'h00;
      run(vecs[v].runCycles);
      chk("vec_xfers", xfers, vecs[v].expXfers);
      chk("vec_last_pc", int'(lastPc), int'(vecs[v].expLast));
    end

    // halt with a read in flight
    run(3);
    halt = 1'b1;
    #1;
    chk("halt_rd", int'(imem_rd), 0);
    nReads = 0;
    cycle();
    run(4);
    #1;
    chk("halt_reads", nReads, 0);
    chk("halt_drained", int'(instr_valid), 0);
    chk("halt_q_empty", q.size(), 0);
    halt = 1'b0;
    run(1);
    #1;
    chk("resume_rd", int'(imem_rd), 1);
    chk("resume_addr", int'(imem_addr), int'(expPc));
    run(4);

    // redirect takes priority while halted
    halt = 1'b1;
    run(3);
    redirect    = 1'b1;
    redirect_pc = 8'h20;
    #1;
    cycle();
    redirect = 1'b0;
    run(2);
    halt = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (instr_valid) begin
        found = 1'b1;
        chk("halt_redir_pc", int'(instr_pc), 8'h20);
        cycle();
        break;
      end
      cycle();
    end
    chk("halt_redir_seen", int'(found), 1);

`ifdef FETCH_PREDECODE_EN
    doRedirect(8'h80);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (!instr_valid) begin
        chk("pd_idle_op", int'(instr_opcode), 0);
        chk("pd_idle_flow", int'(instr_is_flow), 0);
      end else if (instr_pc == 8'h80) begin
        found = 1'b1;
        chk("pd_op9", int'(instr_opcode), 9);
        chk("pd_flow9", int'(instr_is_flow), 1);
        cycle();
        #1;
        chk("pd_pc81", int'(instr_pc), 8'h81);
        chk("pd_op5", int'(instr_opcode), 5);
        chk("pd_flow5", int'(instr_is_flow), 0);
        cycle();
        break;
      end
      cycle();
    end
    chk("pd_seen", int'(found), 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got stuck expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 imem_addr  out  8  program-memory word address (the PC of the issued read).
REQ-005 imem_rd  out  1  read strobe; the word at imem_addr SHALL be presented on imem_data exactly one cycle later.
REQ-006 imem_data  in  10  instruction word returned by program memory.
REQ-007 instr  out  10  instruction word to decode; opcode in bits [9:6].
REQ-008 instr_pc  out  8  address of the word on instr.
REQ-009 instr_valid  out  1  instr and instr_pc are valid.
REQ-010 instr_ready  in  1  decode accepts; a transfer occurs on a clk edge where instr_valid and instr_ready are both 1.
REQ-011 redirect  in  1  one-cycle pulse from jump, return or skip execution; flushes fetch.
REQ-012 redirect_pc  in  8  new PC, sampled when redirect=1.
REQ-013 halt  in  1  level; while 1, no new reads are issued.

Function
REQ-014 The block SHALL hold an 8-bit PC, a 3-entry first-word-fall-through instruction buffer (word plus PC), a 2-bit buffer count, an in-flight flag and a discard flag.
REQ-015 The FSM SHALL have states RUN, HALT and FLUSH: RUN->HALT on halt=1; HALT->RUN on halt=0; any state->FLUSH on redirect=1; FLUSH->RUN (or HALT if halt=1) after exactly one cycle.
REQ-016 imem_rd SHALL be combinational: 1 when state is RUN or FLUSH, halt=0, redirect=0 and (count + in-flight) < 3; imem_addr SHALL always equal PC.
REQ-017 Each issued read SHALL increment PC by 1 modulo 256 (0xFF wraps to 0x00) and set in-flight for the next cycle.
REQ-018 A returning word SHALL be written to the buffer tail with its PC, unless discard=1, in which case it is dropped and discard clears.
REQ-019 instr, instr_pc and instr_valid SHALL reflect the buffer head; instr_valid=1 iff count>0.
REQ-020 With instr_ready held at 1 and no halt or redirect, the block SHALL sustain one transfer per cycle.
REQ-021 Redirect SHALL load PC with redirect_pc, clear the buffer (count=0), and set discard if a read was issued in the same cycle's preceding edge (in-flight=1).
REQ-022 A transfer in the redirect cycle SHALL complete (decode consumes head) before the flush; instr_valid SHALL be 0 in the following cycle.
REQ-023 Redirect SHALL take priority over halt; the PC update happens even while halted.
REQ-024 A simultaneous write and pop on a full buffer SHALL never occur by construction (REQ-016); a simultaneous write and pop at any count SHALL leave count unchanged.
REQ-025 During HALT, an in-flight word SHALL still be written and the buffer SHALL continue draining.

Reset
REQ-026 On rst_n=0: PC=0x00, state=RUN, count=0, in-flight=0, discard=0, instr_valid=0, instr=0, instr_pc=0.
REQ-027 With halt=0, imem_rd SHALL be 1 with imem_addr=0x00 in the first cycle after rst_n deasserts; instr_valid SHALL rise on the second rising edge after deassertion.
REQ-028 Reset asserted mid-operation SHALL discard buffer contents and any in-flight word immediately.

Configuration
REQ-029 Macro FETCH_PREDECODE_EN: when defined, add outputs instr_opcode (4, =instr[9:6]) and instr_is_flow (1, =1 for opcodes 4, 9, 10, 14), both 0 when instr_valid=0; when undefined, these ports do not exist and behaviour is otherwise identical.

Verification
REQ-030 Reset release, halt=0, ready=1, memory word k = k -> reads 0,1,2,...; instr 0x000 with instr_pc 0x00 valid on 2nd edge, then one word per cycle.
REQ-031 ready=0 from start -> exactly 3 reads issued (addr 0,1,2), imem_rd stays 0, count=3; ready=1 -> words 0,1,2 then 3 in order.
REQ-032 Redirect to 0x40 while a read of 0x05 is in flight -> word at 0x05 dropped, next instr_valid carries instr_pc 0x40.
REQ-033 PC reaches 0xFF -> next read address 0x00, instr_pc sequence 0xFE, 0xFF, 0x00.
REQ-034 halt=1 with one read in flight and ready=1 -> that word delivered, no further reads; halt=0 -> resume at the next PC.
REQ-035 With FETCH_PREDECODE_EN, word 0x240 (opcode 9) -> instr_opcode=9, instr_is_flow=1; word 0x140 (opcode 5) -> instr_is_flow=0.
